// File: rtl/dpram_pkg.sv
// Shared constants for the pipelined dual-port RAM: collision policies,
// legal read latencies and the clear/ready state encoding.
package dpram_pkg;

    localparam int COLL_WRITE_FIRST = 0;
    localparam int COLL_READ_FIRST  = 1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-return stage for one port: delays the accepted read word by RD_LAT
// cycles and holds the last returned word while rvalid is low.
module dpram_rd_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata
);

    logic              v1_r;
    logic [DATA_W-1:0] d1_r;

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
        $error("dpram_rd_pipe: RD_LAT must be 1 or 2");
    end

    // First return stage: capture the word of an accepted read
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_r <= 1'b0;
            d1_r <= {DATA_W{1'b0}};
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                d1_r <= in_data;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              v2_r;
        logic [DATA_W-1:0] d2_r;

        // Extra output register stage for the two-cycle latency build
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v2_r <= 1'b0;
                d2_r <= {DATA_W{1'b0}};
            end else begin
                v2_r <= v1_r;
                if (v1_r) begin
                    d2_r <= d1_r;
                end
            end
        end

        assign rvalid = v2_r;
        assign rdata  = d2_r;
    end else begin : g_lat1
        assign rvalid = v1_r;
        assign rdata  = d1_r;
    end

endmodule

// File: rtl/x_dpram_pipe.sv
// True dual-port RAM with byte enables, same-address write merging,
// selectable cross-port read policy and a self-clearing array sweep.
module x_dpram_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 11,
    parameter int RD_LAT    = 1,
    parameter int COLL_MODE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr_req,
    output logic                busy,
    output logic                coll,
    input  logic                a_en,
    input  logic                a_we,
    input  logic [DATA_W/8-1:0] a_be,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_wdata,
    output logic [DATA_W-1:0]   a_rdata,
    output logic                a_rvalid,
    input  logic                b_en,
    input  logic                b_we,
    input  logic [DATA_W/8-1:0] b_be,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_wdata,
    output logic [DATA_W-1:0]   b_rdata,
    output logic                b_rvalid
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam int                NB        = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("x_dpram_pipe: DATA_W must be a multiple of 8");
    end
    if (COLL_MODE != COLL_WRITE_FIRST && COLL_MODE != COLL_READ_FIRST) begin : g_bad_coll
        $error("x_dpram_pipe: COLL_MODE must be 0 or 1");
    end

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [0:0]        state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              busy_r;
    logic              coll_r;

    logic              a_acc_s, b_acc_s;
    logic              a_wr_s, b_wr_s;
    logic              same_addr_s;
    logic [DATA_W-1:0] b_new_s, a_base_s, a_new_s;
    logic [DATA_W-1:0] a_rword_s, b_rword_s;

    assign a_acc_s     = a_en & ~busy_r;
    assign b_acc_s     = b_en & ~busy_r;
    assign a_wr_s      = a_acc_s & a_we;
    assign b_wr_s      = b_acc_s & b_we;
    assign same_addr_s = (a_addr == b_addr);

    // Merged write words; A's word is built on top of B's so A wins per byte
    always_comb begin
        b_new_s = merge_bytes(mem_r[b_addr], b_wdata, b_be);
        if (b_wr_s && same_addr_s) begin
            a_base_s = b_new_s;
        end else begin
            a_base_s = mem_r[a_addr];
        end
        a_new_s = merge_bytes(a_base_s, a_wdata, a_be);
    end

    // Read words; a port never writes while it reads, so only the other port can collide
    always_comb begin
        a_rword_s = mem_r[a_addr];
        b_rword_s = mem_r[b_addr];
        if (COLL_MODE == COLL_WRITE_FIRST && b_wr_s && same_addr_s) begin
            a_rword_s = b_new_s;
        end else begin
            a_rword_s = mem_r[a_addr];
        end
        if (COLL_MODE == COLL_WRITE_FIRST && a_wr_s && same_addr_s) begin
            b_rword_s = a_new_s;
        end else begin
            b_rword_s = mem_r[b_addr];
        end
    end

    // Array storage: clear sweep while busy, otherwise port writes
    always_ff @(posedge clk) begin
        if (busy_r) begin
            mem_r[cnt_r] <= {DATA_W{1'b0}};
        end else begin
            if (b_wr_s) begin
                mem_r[b_addr] <= b_new_s;
            end
            if (a_wr_s) begin
                mem_r[a_addr] <= a_new_s;
            end
        end
    end

    // Clear/ready sequencer and collision flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {ADDR_W{1'b0}};
            busy_r  <= 1'b1;
            coll_r  <= 1'b0;
        end else begin
            coll_r <= a_wr_s & b_wr_s & same_addr_s;
            case (state_r)
                ST_CLEAR: begin
                    cnt_r <= cnt_r + 1'b1;
                    if (cnt_r == LAST_ADDR) begin
                        state_r <= ST_READY;
                        busy_r  <= 1'b0;
                    end
                end
                ST_READY: begin
                    cnt_r <= {ADDR_W{1'b0}};
                    if (clr_req) begin
                        state_r <= ST_CLEAR;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_CLEAR;
                    cnt_r   <= {ADDR_W{1'b0}};
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign coll = coll_r;

    dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_a_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (a_acc_s & ~a_we),
        .in_data  (a_rword_s),
        .rvalid   (a_rvalid),
        .rdata    (a_rdata)
    );

    dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_b_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (b_acc_s & ~b_we),
        .in_data  (b_rword_s),
        .rvalid   (b_rvalid),
        .rdata    (b_rdata)
    );

endmodule
